// File: rtl/counter_pkg.sv
// Shared encodings and default sizing for the counter control stage.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DB_CYCLES_DEF   = 1000;
  localparam int unsigned PRESCALE_W_DEF  = 14;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DIV_W           = 3;

endpackage

// File: rtl/counter_debounce.sv
// Button conditioner: synchroniser, stability counter, accepted level and a
// registered one-cycle pulse on each rising edge of the accepted level.
module counter_debounce
  import counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   level;
  logic                   level_q;

  assign synced = sync[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it has differed for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (synced != level) begin
      if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered press pulse on the accepted level's rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Control stage for the 8-bit loadable counter: conditions pad inputs and
// issues clean load / count_en strobes, preset data and output enable.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned PRESCALE_W  = PRESCALE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              btn_load_raw,
  input  logic              btn_run_raw,
  input  logic [DATA_W-1:0] data_sw_raw,
  input  logic [DIV_W-1:0]  div_sel_raw,
  input  logic              oe_raw,
  output logic              load,
  output logic              count_en,
  output logic [DATA_W-1:0] data_out,
  output logic              oe,
  output logic              running
);

  logic load_press;
  logic run_press;

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync;
  logic [SYNC_STAGES-1:0][DIV_W-1:0]  div_sync;
  logic [SYNC_STAGES-1:0]             oe_sync;
  logic [DATA_W-1:0]                  sw_s;
  logic [DIV_W-1:0]                   div_s;
  logic [DIV_W-1:0]                   div_q;
  logic                               div_change;

  state_e                  state;
  logic                    ret_run;
  logic [PRESCALE_W-1:0]   prescale;
  logic [PRESCALE_W-1:0]   prescale_term;

  counter_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_load_raw),
    .rise  (load_press)
  );

  counter_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_run_raw),
    .rise  (run_press)
  );

  // Synchronisers for the quasi-static switch inputs; oe is the last oe stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync  <= '0;
      div_sync <= '0;
      oe_sync  <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], data_sw_raw};
      div_sync <= {div_sync[SYNC_STAGES-2:0], div_sel_raw};
      oe_sync  <= {oe_sync[SYNC_STAGES-2:0], oe_raw};
    end
  end

  assign sw_s       = sw_sync[SYNC_STAGES-1];
  assign div_s      = div_sync[SYNC_STAGES-1];
  assign oe         = oe_sync[SYNC_STAGES-1];
  assign div_change = (div_s != div_q);

  // Terminal count 4^div_sel - 1, saturating at the full prescaler range.
  always_comb begin
    prescale_term = '1;
    if ((32'(div_s) << 1) < PRESCALE_W) begin
      prescale_term = PRESCALE_W'((32'd1 << (32'(div_s) << 1)) - 32'd1);
    end
  end

  // Run/stop/load FSM with prescaler and registered strobes.
  // LOAD always exits after one cycle, even with ena low, so load stays a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_STOP;
      ret_run  <= 1'b0;
      prescale <= '0;
      div_q    <= '0;
      load     <= 1'b0;
      count_en <= 1'b0;
      data_out <= '0;
      running  <= 1'b0;
    end else begin
      load     <= 1'b0;
      count_en <= 1'b0;
      div_q    <= div_s;
      case (state)
        ST_LOAD: begin
          state    <= ret_run ? ST_RUN : ST_STOP;
          running  <= ret_run;
          prescale <= '0;
        end
        default: begin
          if (ena && load_press) begin
            ret_run  <= (state == ST_RUN);
            state    <= ST_LOAD;
            running  <= 1'b0;
            load     <= 1'b1;
            data_out <= sw_s;
            prescale <= '0;
          end else if (ena && run_press) begin
            state    <= (state == ST_RUN) ? ST_STOP : ST_RUN;
            running  <= (state != ST_RUN);
            prescale <= '0;
          end else if (div_change) begin
            prescale <= '0;
          end else if (ena && state == ST_RUN) begin
            if (prescale == prescale_term) begin
              prescale <= '0;
              count_en <= 1'b1;
            end else begin
              prescale <= prescale + PRESCALE_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: table-driven phases, directed corner sequences and
// randomized stimulus, all checked against a behavioural reference model.
module tb_counter_ctrl;

  localparam int S  = 2;
  localparam int DB = 4;
  localparam int PW = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       btn_load_raw;
  logic       btn_run_raw;
  logic [7:0] data_sw_raw;
  logic [2:0] div_sel_raw;
  logic       oe_raw;
  logic       load;
  logic       count_en;
  logic [7:0] data_out;
  logic       oe;
  logic       running;

  counter_ctrl #(.SYNC_STAGES(S), .DB_CYCLES(DB), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_load_raw (btn_load_raw),
    .btn_run_raw  (btn_run_raw),
    .data_sw_raw  (data_sw_raw),
    .div_sel_raw  (div_sel_raw),
    .oe_raw       (oe_raw),
    .load         (load),
    .count_en     (count_en),
    .data_out     (data_out),
    .oe           (oe),
    .running      (running)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: delay lines, debounce run lengths, mode 0=stop 1=run 2=load.
  bit         q_l[$];
  bit         q_r[$];
  bit         q_oe[$];
  logic [7:0] q_sw[$];
  logic [2:0] q_dv[$];
  bit         acc[2];
  bit         acc_1[2];
  bit         press[2];
  int         run_len[2];
  int         mode;
  int         ret_mode;
  int         phase;
  logic [2:0] prev_dv;
  bit         e_load;
  bit         e_ce;
  bit         e_oe;
  logic [7:0] e_data;

  function automatic int period_of(input logic [2:0] d);
    int p;
    p = 1 << (2 * int'(d));
    if (p > (1 << PW)) p = 1 << PW;
    return p;
  endfunction

  task automatic model_reset();
    q_l = {}; q_r = {}; q_oe = {}; q_sw = {}; q_dv = {};
    for (int i = 0; i < S; i++) begin
      q_l.push_back(1'b0); q_r.push_back(1'b0); q_oe.push_back(1'b0);
      q_sw.push_back(8'h00); q_dv.push_back(3'd0);
    end
    for (int b = 0; b < 2; b++) begin
      acc[b] = 0; acc_1[b] = 0; press[b] = 0; run_len[b] = 0;
    end
    mode = 0; ret_mode = 0; phase = 0; prev_dv = 3'd0;
    e_load = 0; e_ce = 0; e_oe = 0; e_data = 8'h00;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit         syn[2];
    logic [7:0] ssw;
    logic [2:0] sdv;
    bit         pl, pr, nxt;
    ssw = q_sw[S-1];
    sdv = q_dv[S-1];
    syn[0] = q_l[S-1];
    syn[1] = q_r[S-1];
    pl = press[0] && (ena == 1'b1);
    pr = press[1] && (ena == 1'b1);
    e_load = 0;
    e_ce   = 0;
    if (mode == 2) begin
      mode = ret_mode; phase = 0;
    end else if (pl) begin
      ret_mode = mode; mode = 2; e_load = 1; e_data = ssw; phase = 0;
    end else if (pr) begin
      mode = (mode == 1) ? 0 : 1; phase = 0;
    end else if (sdv != prev_dv) begin
      phase = 0;
    end else if (ena == 1'b1 && mode == 1) begin
      if (phase == period_of(sdv) - 1) begin
        e_ce = 1; phase = 0;
      end else begin
        phase++;
      end
    end
    prev_dv = sdv;
    for (int b = 0; b < 2; b++) begin
      press[b] = acc[b] && !acc_1[b];
      nxt = acc[b];
      if (syn[b] != acc[b]) begin
        run_len[b]++;
        if (run_len[b] == DB) begin
          nxt = syn[b]; run_len[b] = 0;
        end
      end else begin
        run_len[b] = 0;
      end
      acc_1[b] = acc[b];
      acc[b]   = nxt;
    end
    q_l.push_front(btn_load_raw);  void'(q_l.pop_back());
    q_r.push_front(btn_run_raw);   void'(q_r.pop_back());
    q_oe.push_front(oe_raw);       void'(q_oe.pop_back());
    q_sw.push_front(data_sw_raw);  void'(q_sw.pop_back());
    q_dv.push_front(div_sel_raw);  void'(q_dv.pop_back());
    e_oe = q_oe[S-1];
  endtask

  task automatic check_model();
    n_vec++;
    if (load !== e_load || count_en !== e_ce || data_out !== e_data ||
        oe !== e_oe || running !== (mode == 1)) begin
      n_bad++;
      $display("FAIL model cyc=%0d got load=%b ce=%b data=%h oe=%b run=%b want load=%b ce=%b data=%h oe=%b run=%b",
               cyc, load, count_en, data_out, oe, running, e_load, e_ce, e_data, e_oe, (mode == 1));
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, got, want, cyc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    cyc++;
  endtask

  // Assert reset between edges, check outputs clear at once, release on the next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    expect_eq("rst_load", 32'(load), 0);
    expect_eq("rst_count_en", 32'(count_en), 0);
    expect_eq("rst_data_out", 32'(data_out), 0);
    expect_eq("rst_oe", 32'(oe), 0);
    expect_eq("rst_running", 32'(running), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         bl;
    bit         br;
    logic [7:0] sw;
    logic [2:0] dv;
    bit         oe;
    bit         en;
    int         cycles;
    int         exp_loads;
    int         exp_ticks;
    bit         exp_run;
    logic [7:0] exp_data;
    bit         exp_oe;
  } row_t;

  row_t tbl[7];

  initial begin
    int loads, ticks, ovl, idx, load_at, ce_at;
    bit seen;

    tbl[0] = '{1'b1, 1'b0, 8'hA5, 3'd1, 1'b1, 1'b1,  8, 1, 0, 1'b0, 8'hA5, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 8'hA5, 3'd1, 1'b1, 1'b1, 12, 0, 0, 1'b0, 8'hA5, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b1,  6, 0, 0, 1'b0, 8'hA5, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'hA5, 3'd1, 1'b1, 1'b1, 30, 0, 7, 1'b1, 8'hA5, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1, 10, 0, 7, 1'b1, 8'hA5, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b1,  6, 0, 6, 1'b1, 8'hA5, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1, 10, 0, 1, 1'b0, 8'hA5, 1'b1};

    ena = 1'b1; btn_load_raw = 1'b0; btn_run_raw = 1'b0;
    data_sw_raw = 8'h00; div_sel_raw = 3'd0; oe_raw = 1'b0;
    do_reset();

    // Table phases: load, release, run press, div 1 ticking, div 0, run held, stop.
    for (int r = 0; r < 7; r++) begin
      btn_load_raw = tbl[r].bl; btn_run_raw = tbl[r].br; data_sw_raw = tbl[r].sw;
      div_sel_raw = tbl[r].dv; oe_raw = tbl[r].oe; ena = tbl[r].en;
      loads = 0; ticks = 0;
      for (int c = 0; c < tbl[r].cycles; c++) begin
        cycle();
        loads += int'(load);
        ticks += int'(count_en);
      end
      expect_eq($sformatf("row%0d_loads", r), 32'(loads), 32'(tbl[r].exp_loads));
      expect_eq($sformatf("row%0d_ticks", r), 32'(ticks), 32'(tbl[r].exp_ticks));
      expect_eq($sformatf("row%0d_running", r), 32'(running), 32'(tbl[r].exp_run));
      expect_eq($sformatf("row%0d_data_out", r), 32'(data_out), 32'(tbl[r].exp_data));
      expect_eq($sformatf("row%0d_oe", r), 32'(oe), 32'(tbl[r].exp_oe));
    end

    // Clean load press latency: load on the 7th cycle after the sampling edge.
    do_reset();
    data_sw_raw = 8'hA5; oe_raw = 1'b0; div_sel_raw = 3'd1;
    repeat (3) cycle();
    btn_load_raw = 1'b1;
    loads = 0; load_at = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (load === 1'b1) begin
        loads++;
        if (load_at < 0) load_at = i;
        expect_eq("press_data_out", 32'(data_out), 32'hA5);
      end
    end
    expect_eq("press_load_count", 32'(loads), 1);
    expect_eq("press_load_cycle", 32'(load_at), 7);
    btn_load_raw = 1'b0;
    repeat (10) cycle();

    // Bouncing load button never settles long enough.
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      btn_load_raw = ((i >> 1) & 1) == 0;
      cycle();
      loads += int'(load);
    end
    btn_load_raw = 1'b0;
    repeat (15) begin
      cycle();
      loads += int'(load);
    end
    expect_eq("bounce_loads", 32'(loads), 0);

    // Enter RUN at div_sel=1, then press load and run in the same cycle.
    btn_run_raw = 1'b1;
    repeat (6) cycle();
    btn_run_raw = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (running === 1'b1) seen = 1;
    end
    expect_eq("enter_run", 32'(seen), 1);
    repeat (8) cycle();
    data_sw_raw = 8'h3C;
    btn_load_raw = 1'b1; btn_run_raw = 1'b1;
    loads = 0; ovl = 0; load_at = -1; ce_at = -1; idx = 0;
    repeat (6) begin
      cycle();
      idx++;
    end
    btn_load_raw = 1'b0; btn_run_raw = 1'b0;
    repeat (20) begin
      cycle();
      idx++;
      if (load === 1'b1) begin
        loads++;
        load_at = idx;
      end
      if (count_en === 1'b1 && load_at >= 0 && ce_at < 0) ce_at = idx;
      if (load === 1'b1 && count_en === 1'b1) ovl++;
    end
    expect_eq("both_load_count", 32'(loads), 1);
    expect_eq("both_overlap", 32'(ovl), 0);
    expect_eq("both_running", 32'(running), 1);
    expect_eq("both_data_out", 32'(data_out), 32'h3C);
    expect_eq("both_resume_gap", 32'(ce_at - load_at), 5);

    // ena low for 10 cycles in RUN with a load press: nothing issued, then ticks resume.
    repeat (8) cycle();
    ena = 1'b0;
    loads = 0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      btn_load_raw = (i < 6);
      cycle();
      loads += int'(load);
      ticks += int'(count_en);
    end
    expect_eq("ena_off_loads", 32'(loads), 0);
    expect_eq("ena_off_ticks", 32'(ticks), 0);
    ena = 1'b1;
    ticks = 0; loads = 0;
    repeat (12) begin
      cycle();
      ticks += int'(count_en);
      loads += int'(load);
    end
    expect_eq("ena_on_ticks", 32'(ticks), 3);
    expect_eq("ena_on_loads", 32'(loads), 0);

    // Reset mid-RUN with a partially counted prescaler.
    div_sel_raw = 3'd2;
    repeat (9) cycle();
    expect_eq("pre_reset_running", 32'(running), 1);
    do_reset();
    btn_load_raw = 1'b0; btn_run_raw = 1'b0; div_sel_raw = 3'd0;
    ticks = 0;
    repeat (10) begin
      cycle();
      ticks += int'(count_en);
    end
    expect_eq("post_reset_running", 32'(running), 0);
    expect_eq("post_reset_ticks", 32'(ticks), 0);

    // Randomized segments against the reference model.
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      hold = int'($urandom_range(1, 14));
      btn_load_raw = ($urandom_range(0, 3) == 0);
      btn_run_raw  = ($urandom_range(0, 2) == 0);
      data_sw_raw  = 8'($urandom);
      div_sel_raw  = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
      oe_raw       = 1'($urandom);
      ena          = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      repeat (hold) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
